dma_controller: RTL and testbench

Single-channel memory-to-memory DMA engine that shares the system data bus with the CPU; CPU always has priority.
- CPU programs it through a standard bus-device register window: chip_select_i, addr_i[5:2], registered read data.
- Copies LEN words from SRC to DST by stealing idle bus cycles, then raises interrupt_o, which feeds a spare interrupt_controller input.
- When m_active_o=1, top muxes m_addr_o, m_read_enable_o, m_write_data_o and m_write_mask_o onto the shared bus. The shared address decoder derives the chip select from m_addr_o.

---
 rtl/dma_controller_pkg.sv | 47 ++++
 rtl/dma_controller.sv | 193 +++++++++++++++++++
 tb/tb_dma_controller.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_pkg.sv
// Shared types and constants for the single-channel memory-to-memory DMA engine.
// Holds the FSM states, the register map, the CTRL/STATUS bit positions and the byte-mask helper.
package dma_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAPT,
        WR
    } dma_state_t;

    // One select per bus device, decoded from the bus address.
    typedef struct packed {
        logic ram;
        logic rom;
        logic uart;
        logic intc;
        logic dma;
    } chip_select_t;

    localparam logic [3:0] DMA_REG_SRC    = 4'd0;
    localparam logic [3:0] DMA_REG_DST    = 4'd1;
    localparam logic [3:0] DMA_REG_LEN    = 4'd2;
    localparam logic [3:0] DMA_REG_CTRL   = 4'd3;
    localparam logic [3:0] DMA_REG_STATUS = 4'd4;
    localparam logic [3:0] DMA_REG_REMAIN = 4'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_FILL   = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = mask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_controller.sv
// Single-channel DMA engine: CPU register window plus an FSM that steals idle shared-bus cycles.
// Optional macro DMA_FILL_EN adds CTRL.FILL: write the SRC value as a constant pattern to LEN words.
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    output logic        interrupt_o,
    input  logic        chip_select_i,
    input  logic [3:0]  addr_i,
    input  logic        read_enable_i,
    output logic [31:0] read_data_o,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_mask_i,
    input  logic        cpu_bus_busy_i,
    output logic        m_active_o,
    output logic [31:0] m_addr_o,
    output logic        m_read_enable_o,
    output logic [31:0] m_write_data_o,
    output logic [3:0]  m_write_mask_o,
    input  logic [31:0] m_read_data_i
);

    dma_state_t       state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [31:0]      wsrc_q, wsrc_d, wdst_q, wdst_d;
    logic [31:0]      buf_q, buf_d, rdata_q, rdata_d;
    logic [LEN_W-1:0] len_q, len_d, remain_q, remain_d;
    logic             irq_en_q, irq_en_d, done_q, done_d, aborted_q, aborted_d;

    logic        busy, wr_en, ctrl_hit, start, abort, fill;
    logic        rd_go, wr_go;
    logic [31:0] reg_rdata;

    assign busy     = (state_q != IDLE);
    assign wr_en    = chip_select_i && (|write_mask_i);
    assign ctrl_hit = wr_en && (addr_i == DMA_REG_CTRL) && write_mask_i[0];
    assign start    = ctrl_hit && write_data_i[CTRL_START];
    assign abort    = ctrl_hit && write_data_i[CTRL_ABORT];

`ifdef DMA_FILL_EN
    logic fill_q, fill_d;

    always_comb begin
        fill_d = fill_q;
        if (ctrl_hit) fill_d = write_data_i[CTRL_FILL];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) fill_q <= 1'b0;
        else           fill_q <= fill_d;
    end

    assign fill = fill_q;
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        // NOTE: every *_d starts from its held value so no path leaves it unassigned (no latches).
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        wsrc_d    = wsrc_q;
        wdst_d    = wdst_q;
        remain_d  = remain_q;
        buf_d     = buf_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        aborted_d = aborted_q;

        if (wr_en && !busy) begin
            case (addr_i)
                DMA_REG_SRC: src_d = apply_wmask(src_q, write_data_i, write_mask_i) & ~32'h3;
                DMA_REG_DST: dst_d = apply_wmask(dst_q, write_data_i, write_mask_i) & ~32'h3;
                DMA_REG_LEN: len_d = LEN_W'(apply_wmask(32'(len_q), write_data_i, write_mask_i));
                default: ;
            endcase
        end
        if (ctrl_hit) irq_en_d = write_data_i[CTRL_IRQ_EN];
        if (wr_en && (addr_i == DMA_REG_STATUS) && write_mask_i[0]) begin
            if (write_data_i[STAT_DONE])    done_d    = 1'b0;
            if (write_data_i[STAT_ABORTED]) aborted_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    wsrc_d    = src_q;
                    wdst_d    = dst_q;
                    remain_d  = len_q;
                    aborted_d = 1'b0;
                    done_d    = (len_q == '0);
                    if (len_q != '0) state_d = fill ? WR : RD;
                end
            end
            RD: if (!cpu_bus_busy_i) state_d = CAPT;
            CAPT: begin
                buf_d   = m_read_data_i;
                state_d = WR;
            end
            WR: begin
                if (!cpu_bus_busy_i) begin
                    wdst_d   = wdst_q + 32'd4;
                    remain_d = remain_q - LEN_W'(1);
                    if (!fill) wsrc_d = wsrc_q + 32'd4;
                    if (remain_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = fill ? WR : RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any completion in the same cycle; counters keep what was moved.
        if (abort && busy) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (addr_i)
            DMA_REG_SRC:    reg_rdata = src_q;
            DMA_REG_DST:    reg_rdata = dst_q;
            DMA_REG_LEN:    reg_rdata = 32'(len_q);
            DMA_REG_CTRL: begin
                reg_rdata[CTRL_IRQ_EN] = irq_en_q;
                reg_rdata[CTRL_FILL]   = fill;
            end
            DMA_REG_STATUS: begin
                reg_rdata[STAT_BUSY]    = busy;
                reg_rdata[STAT_DONE]    = done_q;
                reg_rdata[STAT_ABORTED] = aborted_q;
            end
            DMA_REG_REMAIN: reg_rdata = 32'(remain_q);
            default: ;
        endcase
        rdata_d = (chip_select_i && read_enable_i) ? reg_rdata : '0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            wsrc_q    <= '0;
            wdst_q    <= '0;
            remain_q  <= '0;
            buf_q     <= '0;
            rdata_q   <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            wsrc_q    <= wsrc_d;
            wdst_q    <= wdst_d;
            remain_q  <= remain_d;
            buf_q     <= buf_d;
            rdata_q   <= rdata_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Bus outputs are gated combinationally by cpu_bus_busy_i so the CPU always wins.
    assign rd_go = (state_q == RD) && !cpu_bus_busy_i;
    assign wr_go = (state_q == WR) && !cpu_bus_busy_i;

    assign m_active_o      = rd_go || wr_go;
    assign m_read_enable_o = rd_go;
    assign m_addr_o        = rd_go ? wsrc_q : (wr_go ? wdst_q : 32'd0);
    assign m_write_data_o  = wr_go ? (fill ? wsrc_q : buf_q) : 32'd0;
    assign m_write_mask_o  = wr_go ? 4'hF : 4'h0;
    assign read_data_o     = rdata_q;
    assign interrupt_o     = done_q && irq_en_q;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: random memory contents and bus contention,
// checked against a word-list model of the copy (address/data per word).
module tb_dma_controller;

    localparam int LEN_W = 16;
    localparam logic [3:0] R_SRC = 4'd0, R_DST = 4'd1, R_LEN = 4'd2,
                           R_CTRL = 4'd3, R_STATUS = 4'd4, R_REMAIN = 4'd5;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        interrupt_o;
    logic        chip_select_i;
    logic [3:0]  addr_i;
    logic        read_enable_i;
    logic [31:0] read_data_o;
    logic [31:0] write_data_i;
    logic [3:0]  write_mask_i;
    logic        cpu_bus_busy_i;
    logic        m_active_o;
    logic [31:0] m_addr_o;
    logic        m_read_enable_o;
    logic [31:0] m_write_data_o;
    logic [3:0]  m_write_mask_o;
    logic [31:0] m_read_data_i = 32'd0;

    dma_controller #(.LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .interrupt_o(interrupt_o),
        .chip_select_i(chip_select_i), .addr_i(addr_i), .read_enable_i(read_enable_i),
        .read_data_o(read_data_o), .write_data_i(write_data_i), .write_mask_i(write_mask_i),
        .cpu_bus_busy_i(cpu_bus_busy_i), .m_active_o(m_active_o), .m_addr_o(m_addr_o),
        .m_read_enable_o(m_read_enable_o), .m_write_data_o(m_write_data_o),
        .m_write_mask_o(m_write_mask_o), .m_read_data_i(m_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave and observer: memory image, observed DMA transactions, contention count.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] obs_rd[$], obs_wa[$], obs_wd[$];
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
    int          n_active, n_conflict;
    int unsigned last_wr_cyc, start_cyc;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'd0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hBAD0_0000;
    endfunction

    always @(negedge clk_i) begin
        rd_pend = 1'b0;
        if (reset_ni && m_active_o) begin
            n_active++;
            if (cpu_bus_busy_i) n_conflict++;
            if (m_read_enable_o) begin
                obs_rd.push_back(m_addr_o);
                rd_pend = 1'b1;
                rd_addr = m_addr_o;
            end
            if (m_write_mask_o == 4'hF) begin
                obs_wa.push_back(m_addr_o);
                obs_wd.push_back(m_write_data_o);
                mem[m_addr_o] = m_write_data_o;
                last_wr_cyc   = cyc;
            end
        end
    end

    // Read data is valid only in the cycle after the read; garbage otherwise.
    always @(posedge clk_i) m_read_data_i <= rd_pend ? mem_rd(rd_addr) : $urandom;

    int   busy_mode = 0;
    logic tog = 1'b0;

    function automatic logic bg_busy();
        case (busy_mode)
            1:       begin tog = ~tog; return tog; end
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_cycle();
        chip_select_i  = 1'b0;
        read_enable_i  = 1'b0;
        write_mask_i   = 4'h0;
        cpu_bus_busy_i = bg_busy();
        @(posedge clk_i); #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
        chip_select_i  = 1'b1;
        read_enable_i  = 1'b0;
        addr_i         = a;
        write_data_i   = d;
        write_mask_i   = m;
        cpu_bus_busy_i = 1'b1;
        @(posedge clk_i); #1;
        start_cyc      = cyc;
        chip_select_i  = 1'b0;
        write_mask_i   = 4'h0;
        cpu_bus_busy_i = bg_busy();
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        chip_select_i  = 1'b1;
        read_enable_i  = 1'b1;
        addr_i         = a;
        write_mask_i   = 4'h0;
        cpu_bus_busy_i = 1'b1;
        @(posedge clk_i); #1;
        chip_select_i  = 1'b0;
        read_enable_i  = 1'b0;
        cpu_bus_busy_i = bg_busy();
        d = read_data_o;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic clear_obs();
        obs_rd.delete(); obs_wa.delete(); obs_wd.delete();
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        n_active   = 0;
        n_conflict = 0;
    endtask

    // Reference: word i is read from src+4i and written unchanged to dst+4i, modulo 2^32.
    task automatic build_expect(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] sa, da;
        for (int i = 0; i < len; i++) begin
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            mem[sa] = $urandom;
            exp_rd.push_back(sa);
            exp_wa.push_back(da);
            exp_wd.push_back(mem[sa]);
        end
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && obs_wa.size() < n; i++) idle_cycle();
        check({tag, "_nwrites"}, 32'(obs_wa.size()), 32'(n));
        idle_cycle();
        idle_cycle();
    endtask

    task automatic compare_bus(input string tag);
        check({tag, "_nreads"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check($sformatf("%s_rdaddr%0d", tag, i), obs_rd[i], exp_rd[i]);
        check({tag, "_nwr"}, 32'(obs_wa.size()), 32'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
            check($sformatf("%s_wraddr%0d", tag, i), obs_wa[i], exp_wa[i]);
            check($sformatf("%s_wrdata%0d", tag, i), obs_wd[i], exp_wd[i]);
        end
        check({tag, "_conflict"}, 32'(n_conflict), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [31:0] s, d;
        int len;

        reset_ni = 1'b0;
        chip_select_i = 1'b0; addr_i = 4'd0; read_enable_i = 1'b0;
        write_data_i = 32'd0; write_mask_i = 4'h0; cpu_bus_busy_i = 1'b0;
        #1;
        check("rst_active", 32'(m_active_o), 32'd0);
        check("rst_irq", 32'(interrupt_o), 32'd0);
        check("rst_rdata", read_data_o, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        idle_cycle();
        read_check("rst_status", R_STATUS, 32'd0);

        // Basic copy with idle CPU: 3 cycles per word.
        clear_obs();
        busy_mode = 0;
        reg_write(R_SRC, 32'h100);
        reg_write(R_DST, 32'h200);
        reg_write(R_LEN, 32'd4);
        build_expect(32'h100, 32'h200, 4);
        reg_write(R_CTRL, 32'h1);
        wait_writes("t1", 4, 100);
        compare_bus("t1");
        check("t1_cycles", last_wr_cyc + 1 - start_cyc, 32'd12);
        read_check("t1_status", R_STATUS, 32'h2);
        read_check("t1_remain", R_REMAIN, 32'd0);
        read_check("t1_src", R_SRC, 32'h100);

        // Byte-masked write, low two address bits read zero.
        reg_write(R_DST, 32'hFFFF_FFFF, 4'b0011);
        read_check("mask_dst", R_DST, 32'h0000_FFFC);
        reg_write(R_DST, 32'h200);

        // Toggling contention, interrupt, register writes ignored while busy.
        clear_obs();
        busy_mode = 1;
        build_expect(32'h100, 32'h200, 4);
        reg_write(R_CTRL, 32'h3);
        idle_cycle();
        reg_write(R_SRC, 32'hDEAD_0000);
        reg_write(R_LEN, 32'd9);
        wait_writes("t2", 4, 200);
        compare_bus("t2");
        check("t2_irq_on", 32'(interrupt_o), 32'd1);
        read_check("t2_src_kept", R_SRC, 32'h100);
        read_check("t2_len_kept", R_LEN, 32'd4);
        read_check("t2_ctrl", R_CTRL, 32'h2);
        reg_write(R_STATUS, 32'h2);
        check("t2_irq_off", 32'(interrupt_o), 32'd0);

        // LEN = 0: done immediately, no bus cycles.
        clear_obs();
        busy_mode = 0;
        reg_write(R_LEN, 32'd0);
        reg_write(R_CTRL, 32'h3);
        check("t3_irq_next", 32'(interrupt_o), 32'd1);
        repeat (5) idle_cycle();
        check("t3_active", 32'(n_active), 32'd0);
        read_check("t3_status", R_STATUS, 32'h2);
        reg_write(R_STATUS, 32'h2);

        // Abort after the third write of eight.
        clear_obs();
        reg_write(R_SRC, 32'h400);
        reg_write(R_DST, 32'h600);
        reg_write(R_LEN, 32'd8);
        build_expect(32'h400, 32'h600, 3);
        reg_write(R_CTRL, 32'h1);
        for (int i = 0; i < 100 && obs_wa.size() < 3; i++) idle_cycle();
        reg_write(R_CTRL, 32'h4);
        snap = n_active;
        repeat (10) idle_cycle();
        check("t4_quiet", 32'(n_active), 32'(snap));
        compare_bus("t4");
        read_check("t4_status", R_STATUS, 32'h4);
        read_check("t4_remain", R_REMAIN, 32'd5);

        // START and ABORT together: abort wins, nothing starts; ABORT in idle does nothing.
        reg_write(R_CTRL, 32'h5);
        repeat (4) idle_cycle();
        check("t4b_quiet", 32'(n_active), 32'(snap));
        read_check("t4b_status", R_STATUS, 32'h4);
        reg_write(R_STATUS, 32'h4);
        reg_write(R_CTRL, 32'h4);
        read_check("t4c_status", R_STATUS, 32'h0);

        // Address wrap with random contention.
        clear_obs();
        busy_mode = 2;
        reg_write(R_SRC, 32'hFFFF_FFF8);
        reg_write(R_DST, 32'h300);
        reg_write(R_LEN, 32'd3);
        build_expect(32'hFFFF_FFF8, 32'h300, 3);
        reg_write(R_CTRL, 32'h1);
        wait_writes("t5", 3, 300);
        compare_bus("t5");
        check("t5_rd2_wrapped", exp_rd[2], 32'h0);

        // Randomized transfers.
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            s   = 32'h1000 + 32'(4 * $urandom_range(0, 255));
            d   = 32'h8000 + 32'(4 * $urandom_range(0, 255));
            len = $urandom_range(1, 6);
            reg_write(R_SRC, s);
            reg_write(R_DST, d);
            reg_write(R_LEN, 32'(len));
            build_expect(s, d, len);
            reg_write(R_CTRL, 32'h1);
            wait_writes($sformatf("r%0d", k), len, 400);
            compare_bus($sformatf("r%0d", k));
            read_check($sformatf("r%0d_status", k), R_STATUS, 32'h2);
            reg_write(R_STATUS, 32'h2);
        end

        // Asynchronous reset while a write is on the bus.
        clear_obs();
        busy_mode = 0;
        reg_write(R_SRC, 32'h100);
        reg_write(R_DST, 32'h700);
        reg_write(R_LEN, 32'd4);
        reg_write(R_CTRL, 32'h3);
        for (int i = 0; i < 30; i++) begin
            idle_cycle();
            if (m_write_mask_o == 4'hF) break;
        end
        check("t7_in_wr", 32'(m_write_mask_o), 32'hF);
        #2 reset_ni = 1'b0;
        #1;
        check("t7_active", 32'(m_active_o), 32'd0);
        check("t7_addr", m_addr_o, 32'd0);
        check("t7_wdata", m_write_data_o, 32'd0);
        check("t7_wmask", 32'(m_write_mask_o), 32'd0);
        check("t7_rden", 32'(m_read_enable_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        idle_cycle();
        for (int a = 0; a < 8; a++)
            read_check($sformatf("t7_reg%0d", a), 4'(a), 32'd0);
        check("t7_irq", 32'(interrupt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
